// File: rtl/dense_layer_seq.sv
// dense_layer_seq: y = act(x*W + b) over COUNT samples using one time-multiplexed
// signed fixed-point MAC, with per-neuron bias, selectable activation and saturation.
module dense_layer_seq #(
  parameter int unsigned IN_SIZE  = 4,
  parameter int unsigned OUT_SIZE = 2,
  parameter int unsigned COUNT    = 1,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned FRAC_W   = 8,
  parameter int unsigned ACC_W    = 40
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     enable,
  input  logic [1:0]                               act_sel,
  input  logic [COUNT-1:0][IN_SIZE-1:0][DATA_W-1:0] data_in,
  input  logic [IN_SIZE-1:0][OUT_SIZE-1:0][DATA_W-1:0] weights,
  input  logic [OUT_SIZE-1:0][DATA_W-1:0]           bias,
  output logic                                     busy,
  output logic                                     done,
  output logic [COUNT-1:0][OUT_SIZE-1:0][DATA_W-1:0] data_out,
  output logic                                     sat_flag
);

  localparam int unsigned K_W = (IN_SIZE  > 1) ? $clog2(IN_SIZE)  : 1;
  localparam int unsigned C_W = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam int unsigned R_W = (COUNT    > 1) ? $clog2(COUNT)    : 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_WRITE, S_DONE} state_t;

  state_t state_q, state_d;

  logic [COUNT-1:0][IN_SIZE-1:0][DATA_W-1:0]    x_q;
  logic [IN_SIZE-1:0][OUT_SIZE-1:0][DATA_W-1:0] w_q;
  logic [OUT_SIZE-1:0][DATA_W-1:0]              b_q;
  logic [1:0]                                   act_q;
  logic [K_W-1:0]                               k_q;
  logic [C_W-1:0]                               c_q;
  logic [R_W-1:0]                               r_q;
  logic signed [ACC_W-1:0]                      acc_q;

  logic                       last_k_c, last_c_c, last_r_c;
  logic [C_W-1:0]             c_next_c;
  logic signed [DATA_W-1:0]   x_c, w_c, sel_bias_c, res_c;
  logic signed [2*DATA_W-1:0] prod_c;
  logic signed [ACC_W-1:0]    bias_acc_c, v_c, act_c, sat_c;
  logic                       clip_c;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    last_k_c = (k_q == K_W'(IN_SIZE - 1));
    last_c_c = (c_q == C_W'(OUT_SIZE - 1));
    last_r_c = (r_q == R_W'(COUNT - 1));
    case (state_q)
      S_IDLE:  if (enable) state_d = S_MAC;
      S_MAC:   if (last_k_c) state_d = S_WRITE;
      S_WRITE: state_d = (last_c_c && last_r_c) ? S_DONE : S_MAC;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // MAC product, bias preload, activation and saturation of the current neuron
  always_comb begin
    c_next_c   = last_c_c ? '0 : C_W'(c_q + 1'b1);
    sel_bias_c = (state_q == S_IDLE) ? $signed(bias[0]) : $signed(b_q[c_next_c]);
    bias_acc_c = ACC_W'(sel_bias_c) <<< FRAC_W;
    x_c        = $signed(x_q[r_q][k_q]);
    w_c        = $signed(w_q[k_q][c_q]);
    prod_c     = x_c * w_c;
    v_c        = acc_q >>> FRAC_W;
    case (act_q)
      2'd1:    act_c = v_c[ACC_W-1] ? '0 : v_c;
      2'd2:    act_c = v_c[ACC_W-1] ? (v_c >>> 3) : v_c;
      default: act_c = v_c;
    endcase
    clip_c = 1'b0;
    sat_c  = act_c;
    if (act_c > SAT_MAX) begin
      sat_c  = SAT_MAX;
      clip_c = 1'b1;
    end else if (act_c < SAT_MIN) begin
      sat_c  = SAT_MIN;
      clip_c = 1'b1;
    end
    res_c = DATA_W'(sat_c);
  end

  // Datapath, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q      <= '0;
      w_q      <= '0;
      b_q      <= '0;
      act_q    <= '0;
      k_q      <= '0;
      c_q      <= '0;
      r_q      <= '0;
      acc_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sat_flag <= 1'b0;
      data_out <= '0;
    end else begin
      busy <= (state_d != S_IDLE);
      done <= (state_d == S_DONE);
      case (state_q)
        S_IDLE: begin
          if (enable) begin
            x_q      <= data_in;
            w_q      <= weights;
            b_q      <= bias;
            act_q    <= act_sel;
            k_q      <= '0;
            c_q      <= '0;
            r_q      <= '0;
            acc_q    <= bias_acc_c;
            sat_flag <= 1'b0;
          end
        end
        S_MAC: begin
          acc_q <= acc_q + ACC_W'(prod_c);
          k_q   <= K_W'(k_q + 1'b1);
        end
        S_WRITE: begin
          data_out[r_q][c_q] <= res_c;
          if (clip_c) sat_flag <= 1'b1;
          k_q   <= '0;
          c_q   <= c_next_c;
          if (last_c_c) r_q <= R_W'(r_q + 1'b1);
          acc_q <= bias_acc_c;
        end
        default: ;
      endcase
    end
  end

endmodule
